// File: rtl/rr_arbiter_pkg.sv
// Types and helpers shared by the round-robin arbiter and its priority picker.
// Pure declarations, no logic.
package rr_arbiter_pkg;

`include "rr_arbiter_defs.vh"

    typedef enum logic {
        ST_IDLE = `RR_ST_IDLE,
        ST_BUSY = `RR_ST_BUSY
    } rr_state_e;

    // Ring position k steps away from idx in the rotation direction.
    function automatic int rr_step(input int idx, input int k, input int n, input bit left);
        if (left) begin
            return (idx + k) % n;
        end
        return (idx + n - k) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter_defs.vh
// Shared FSM state encodings for the round-robin arbiter.
`ifndef RR_ARBITER_DEFS_VH
`define RR_ARBITER_DEFS_VH

`define RR_ST_IDLE 1'b0
`define RR_ST_BUSY 1'b1

`endif

// File: rtl/rr_arbiter_pick.sv
// Circular priority search: first set request at or after the one-hot pointer.
// Purely combinational, zero latency, no flow control.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int LEFT = 1,
    parameter int IW   = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  ptr_i,
    output logic [N-1:0]  winner_o,
    output logic [IW-1:0] winner_idx_o,
    output logic          any_o
);

    int            p;
    int            j;
    logic [IW-1:0] jj;
    logic          found;

    always_comb begin
        p            = 0;
        j            = 0;
        jj           = '0;
        found        = 1'b0;
        winner_o     = '0;
        winner_idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_i[i]) begin
                p = i;
            end
        end
        for (int k = 0; k < N; k++) begin
            j  = rr_step(p, k, N, LEFT != 0);
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found         = 1'b1;
                winner_o[jj]  = 1'b1;
                winner_idx_o  = jj;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded grant hold; grant registered one cycle after request.
// Requesters hold req as a level; a grant is revoked on release or after MAX_HOLD cycles.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int LEFT     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int            IW        = $clog2(N);
    localparam int            HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  PTR_RST   = N'(1);

    rr_state_e     state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          grant_vld_q, grant_vld_d;

    logic [N-1:0]  win;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic [N-1:0]  win_rot;
    logic          owner_req;

    rr_pick #(
        .N    (N),
        .LEFT (LEFT),
        .IW   (IW)
    ) u_pick (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .winner_o     (win),
        .winner_idx_o (win_idx),
        .any_o        (win_any)
    );

    // Pointer moves one past the winner so the winner becomes lowest priority.
    generate
        if (LEFT != 0) begin : g_rot_left
            assign win_rot = {win[N-2:0], win[N-1]};
        end else begin : g_rot_right
            assign win_rot = {win[0], win[N-1:1]};
        end
    endgenerate

    assign owner_req = |(req & grant_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d     = ST_BUSY;
                    ptr_d       = win_rot;
                    hold_cnt_d  = '0;
                    grant_d     = win;
                    grant_id_d  = win_idx;
                    grant_vld_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // Release takes precedence; expiry yields the same idle result.
                if (!owner_req || hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_IDLE;
                    hold_cnt_d  = '0;
                    grant_d     = '0;
                    grant_id_d  = '0;
                    grant_vld_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_RST;
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
        end
    end

    always_comb begin
        assert ($onehot0(grant_q));
    end

    assign grant       = grant_q;
    assign grant_valid = grant_vld_q;
    assign grant_id    = grant_id_q;

endmodule
